// File: rtl/tlc_apb_sequencer_if.sv
// APB bus bundle between tlc_apb_sequencer (master) and the traffic-light slave.
interface tlc_apb_sequencer_if;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;

   modport master (
      output paddr, pwdata, psel, penable, pwrite,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  paddr, pwdata, psel, penable, pwrite,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/tlc_apb_sequencer.sv
// APB master that steps the traffic-light slave through its six phases and verifies each one.
// Optional manual stepping (extra input port step) is enabled by defining TLC_SEQ_MANUAL_STEP_EN.
module tlc_apb_sequencer #(
   parameter logic [31:0]      ADDR_STAT = 32'h0000_0000,
   parameter logic [31:0]      ADDR_CTRL = 32'h0000_0004,
   parameter int unsigned      CNT_W     = 16,
   parameter logic [CNT_W-1:0] T_GREEN   = 16'd16,
   parameter logic [CNT_W-1:0] T_YELLOW  = 16'd4,
   parameter logic [CNT_W-1:0] T_ALLRED  = 16'd2,
   parameter int unsigned      TIMEOUT   = 15
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 en,
`ifdef TLC_SEQ_MANUAL_STEP_EN
   input  logic                 step,
`endif
   tlc_apb_sequencer_if.master  bus,
   output logic [2:0]           phase,
   output logic [31:0]          status,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [3:0] {
      INIT_RD  = 4'd0,
      DWELL    = 4'd1,
      W_SETUP  = 4'd2,
      W_ACCESS = 4'd3,
      GAP      = 4'd4,
      R_SETUP  = 4'd5,
      R_ACCESS = 4'd6,
      CHECK    = 4'd7,
      FAULT    = 4'd8
   } state_t;

   localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [WAIT_W-1:0] wait_r;
   logic              step_s;

   // Lamp word the slave must report in each phase (A lamp in [2:0], B lamp in [18:16]).
   function automatic logic [31:0] expected_status(input logic [2:0] ph);
      logic [31:0] s;
      case (ph)
         3'd0:    s = 32'h0001_0004;
         3'd1:    s = 32'h0001_0002;
         3'd2:    s = 32'h0001_0001;
         3'd3:    s = 32'h0004_0001;
         3'd4:    s = 32'h0002_0001;
         3'd5:    s = 32'h0001_0001;
         default: s = 32'h0000_0000;
      endcase
      return s;
   endfunction

   // Terminal count of the dwell counter; a zero dwell behaves as one cycle.
   function automatic logic [CNT_W-1:0] dwell_last(input logic [2:0] ph);
      logic [CNT_W-1:0] d;
      case (ph)
         3'd0, 3'd3: d = T_GREEN;
         3'd1, 3'd4: d = T_YELLOW;
         default:    d = T_ALLRED;
      endcase
      return (d == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : d - CNT_W'(1'b1);
   endfunction

`ifdef TLC_SEQ_MANUAL_STEP_EN
   assign step_s = step;
`else
   assign step_s = 1'b0;
`endif

   // Sequencer FSM; all bus and status outputs are registered here.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_r     <= INIT_RD;
         cnt_r       <= {CNT_W{1'b0}};
         wait_r      <= {WAIT_W{1'b0}};
         bus.paddr   <= 32'h0000_0000;
         bus.pwdata  <= 32'h0000_0000;
         bus.psel    <= 1'b0;
         bus.penable <= 1'b0;
         bus.pwrite  <= 1'b0;
         phase       <= 3'd0;
         status      <= 32'h0000_0000;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         case (state_r)
            INIT_RD, GAP: begin
               state_r     <= R_SETUP;
               bus.psel    <= 1'b1;
               bus.penable <= 1'b0;
               bus.pwrite  <= 1'b0;
               bus.paddr   <= ADDR_STAT;
               bus.pwdata  <= 32'h0000_0000;
               busy        <= 1'b1;
            end
            DWELL: begin
               if (step_s || (en && (cnt_r == dwell_last(phase)))) begin
                  cnt_r       <= {CNT_W{1'b0}};
                  state_r     <= W_SETUP;
                  bus.psel    <= 1'b1;
                  bus.penable <= 1'b0;
                  bus.pwrite  <= 1'b1;
                  bus.paddr   <= ADDR_CTRL;
                  bus.pwdata  <= 32'h0000_0001;
                  busy        <= 1'b1;
               end else if (en) begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            W_SETUP, R_SETUP: begin
               state_r     <= (state_r == W_SETUP) ? W_ACCESS : R_ACCESS;
               bus.penable <= 1'b1;
               wait_r      <= {WAIT_W{1'b0}};
            end
            W_ACCESS, R_ACCESS: begin
               if (bus.pready) begin
                  bus.psel    <= 1'b0;
                  bus.penable <= 1'b0;
                  bus.pwrite  <= 1'b0;
                  bus.paddr   <= 32'h0000_0000;
                  bus.pwdata  <= 32'h0000_0000;
                  busy        <= 1'b0;
                  if (state_r == R_ACCESS) begin
                     status <= bus.prdata;
                  end
                  // A failed write leaves phase untouched so it still names the slave's real phase.
                  if (bus.pslverr) begin
                     state_r <= FAULT;
                     err     <= 1'b1;
                  end else if (state_r == W_ACCESS) begin
                     phase   <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                     state_r <= GAP;
                  end else begin
                     state_r <= CHECK;
                  end
               end else if (wait_r == WAIT_LAST) begin
                  state_r     <= FAULT;
                  err         <= 1'b1;
                  bus.psel    <= 1'b0;
                  bus.penable <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  wait_r <= wait_r + WAIT_W'(1'b1);
               end
            end
            CHECK: begin
               if (status == expected_status(phase)) begin
                  state_r <= DWELL;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  state_r <= FAULT;
                  err     <= 1'b1;
               end
            end
            FAULT: begin
               state_r     <= FAULT;
               bus.psel    <= 1'b0;
               bus.penable <= 1'b0;
               busy        <= 1'b0;
               err         <= 1'b1;
            end
            default: begin
               state_r     <= FAULT;
               bus.psel    <= 1'b0;
               bus.penable <= 1'b0;
               busy        <= 1'b0;
               err         <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlc_apb_sequencer.sv
// Directed/randomized bench for tlc_apb_sequencer with a transaction-level traffic-light slave model.
module tb_tlc_apb_sequencer;
   logic        pclk    = 1'b0;
   logic        presetn = 1'b0;
   logic        en      = 1'b0;
`ifdef TLC_SEQ_MANUAL_STEP_EN
   logic        step    = 1'b0;
`endif
   logic [2:0]  phase;
   logic [31:0] status;
   logic        busy;
   logic        err;
   int          errors = 0;
   int          checks = 0;

   tlc_apb_sequencer_if bus ();

   tlc_apb_sequencer dut (
      .pclk    (pclk),
      .presetn (presetn),
      .en      (en),
`ifdef TLC_SEQ_MANUAL_STEP_EN
      .step    (step),
`endif
      .bus     (bus),
      .phase   (phase),
      .status  (status),
      .busy    (busy),
      .err     (err)
   );

   initial forever #5 pclk = ~pclk;

   // Lamp word from the traffic rules: A is green/yellow in phases 0/1, B in phases 3/4, red otherwise.
   function automatic logic [31:0] exp_stat(input int p);
      logic [2:0] a;
      logic [2:0] b;
      a = (p == 0) ? 3'b100 : (p == 1) ? 3'b010 : 3'b001;
      b = (p == 3) ? 3'b100 : (p == 4) ? 3'b010 : 3'b001;
      return {13'd0, b, 13'd0, a};
   endfunction

   function automatic int dwell_of(input int p);
      int t;
      t = (p % 3 == 0) ? 16 : (p % 3 == 1) ? 4 : 2;
      return (t == 0) ? 1 : t;
   endfunction

   task automatic tick();
      @(negedge pclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      presetn     = 1'b0;
      en          = 1'b1;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0000_0000;
`ifdef TLC_SEQ_MANUAL_STEP_EN
      step        = 1'b0;
`endif
      tick();
      tick();
      check("rst_ctl", 32'({bus.psel, bus.penable, bus.pwrite, busy, err}), 32'd0);
      check("rst_addr_data", bus.paddr | bus.pwdata, 32'd0);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_status", status, 32'd0);
      presetn = 1'b1;
   endtask

   // Idle until a SETUP appears; counts enabled cycles after the first (checking) cycle, with optional en drop.
   task automatic idle_wait(input int drop_at, input int drop_len, output int en_cnt, output int cyc);
      int left;
      left   = drop_len;
      en_cnt = 0;
      cyc    = 0;
      while (!(bus.psel && !bus.penable) && cyc < 300) begin
         if (cyc > 0) begin
            if (en_cnt == drop_at && left > 0) begin
               en = 1'b0;
               left--;
            end else begin
               en = 1'b1;
               en_cnt++;
            end
         end
         cyc++;
         tick();
      end
      en = 1'b1;
      check("idle_bound", 32'(cyc < 300), 32'd1);
   endtask

   // Slave side of one transfer, entered at the SETUP cycle; ends one cycle after completion.
   task automatic serve_xfer(input bit is_wr, input int waits, input bit slverr, input logic [31:0] rdata);
      check("setup_ctl", 32'({bus.psel, bus.penable, bus.pwrite, busy}), 32'({1'b1, 1'b0, is_wr, 1'b1}));
      check("setup_addr", bus.paddr, is_wr ? 32'h0000_0004 : 32'h0000_0000);
      check("setup_wdata", bus.pwdata, is_wr ? 32'h0000_0001 : 32'h0000_0000);
      tick();
      for (int i = 0; i <= waits; i++) begin
         check("access_ctl", 32'({bus.psel, bus.penable, bus.pwrite, busy, bus.paddr[3:0]}),
               32'({1'b1, 1'b1, is_wr, 1'b1, is_wr ? 4'h4 : 4'h0}));
         if (i == waits) begin
            bus.pready  = 1'b1;
            bus.pslverr = slverr;
            bus.prdata  = rdata;
         end
         tick();
      end
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0000_0000;
   endtask

   initial begin : stim
      int ec;
      int cyc;
      int ph;
      int d;
      int da;
      int dl;

      // Full cycle from reset with random wait states and random en drops.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      check("init_latency", 32'(cyc), 32'd1);
      serve_xfer(1'b0, int'($urandom_range(4)), 1'b0, exp_stat(0));
      check("status_p0", status, exp_stat(0));
      check("check_idle", 32'({bus.psel, bus.penable, busy}), 32'd0);
      ph = 0;
      for (int i = 0; i < 6; i++) begin
         d = dwell_of(ph);
         if (i == 0) begin
            da = 5;
            dl = 10;
         end else begin
            da = int'($urandom_range(d - 1));
            dl = int'($urandom_range(6));
         end
         idle_wait(da, dl, ec, cyc);
         check("dwell_en_cycles", 32'(ec), 32'(d));
         check("dwell_total_cycles", 32'(cyc), 32'(1 + d + dl));
         check("err_clear", 32'(err), 32'd0);
         serve_xfer(1'b1, int'($urandom_range(4)), 1'b0, 32'h0000_0000);
         ph = (ph + 1) % 6;
         check("gap_idle", 32'({bus.psel, bus.penable, busy}), 32'd0);
         check("phase_adv", 32'(phase), 32'(ph));
         tick();
         serve_xfer(1'b0, int'($urandom_range(4)), 1'b0, exp_stat(ph));
         check("status_rd", status, exp_stat(ph));
      end

      // Reset asserted while the readback is in SETUP releases the bus at once.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      serve_xfer(1'b0, 0, 1'b0, exp_stat(0));
      idle_wait(-1, 0, ec, cyc);
      serve_xfer(1'b1, 0, 1'b0, 32'h0000_0000);
      check("mid_phase1", 32'(phase), 32'd1);
      tick();
      check("mid_rsetup", 32'(bus.psel), 32'd1);
      presetn = 1'b0;
      #1;
      check("async_release", 32'({bus.psel, bus.penable, busy}), 32'd0);
      check("async_phase", 32'(phase), 32'd0);

      // Slave error on the CTRL write.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      serve_xfer(1'b0, 0, 1'b0, exp_stat(0));
      idle_wait(-1, 0, ec, cyc);
      check("slverr_dwell", 32'(ec), 32'd16);
      serve_xfer(1'b1, 1, 1'b1, 32'h0000_0000);
      check("slverr_fault", 32'({err, bus.psel, bus.penable, busy}), 32'b1000);
      check("slverr_phase", 32'(phase), 32'd0);
      repeat (5) tick();
      check("slverr_sticky", 32'({err, bus.psel}), 32'b10);

      // Slave never asserts pready during the readback.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      tick();
      for (int i = 0; i < 15; i++) begin
         check("timeout_wait", 32'({err, bus.psel, bus.penable}), 32'b011);
         tick();
      end
      check("timeout_fault", 32'({err, bus.psel, busy}), 32'b100);

      // Wrong lamp word in phase 0.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      serve_xfer(1'b0, 0, 1'b0, 32'h0001_0001);
      check("mismatch_status", status, 32'h0001_0001);
      tick();
      check("mismatch_fault", 32'({err, bus.psel, busy}), 32'b100);

`ifdef TLC_SEQ_MANUAL_STEP_EN
      // Manual step at dwell count 2 starts the write on the following cycle.
      do_reset();
      idle_wait(-1, 0, ec, cyc);
      serve_xfer(1'b0, 0, 1'b0, exp_stat(0));
      tick();
      tick();
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_setup", 32'({bus.psel, bus.penable, bus.pwrite}), 32'b101);
      serve_xfer(1'b1, 0, 1'b0, 32'h0000_0000);
      check("step_phase", 32'(phase), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlc_apb_sequencer.md
Name: tlc_apb_sequencer

Overview:
- APB master that autonomously drives the traffic-light APB slave through its six-phase cycle.
- Each phase is held for a programmed dwell time. The sequencer then writes the CTRL "next" command and reads back the lamp status to confirm the slave reached the expected phase.
- Sits between the system timebase and the traffic-light slave as its only APB master. Reports the current phase, the last status read, and a sticky fault flag.

Parameters:
- ADDR_STAT, 32'h0000_0000, address of the lamp status register (read)
- ADDR_CTRL, 32'h0000_0004, address of the CTRL register (write bit0=1 advances the phase)
- CNT_W, 16, dwell counter width
- T_GREEN, 16, dwell cycles for phases 0 and 3
- T_YELLOW, 4, dwell cycles for phases 1 and 4
- T_ALLRED, 2, dwell cycles for phases 2 and 5
- TIMEOUT, 15, maximum ACCESS cycles waiting for pready before a fault

Ports:
- pclk  in  1  clock
- presetn  in  1  reset, asynchronous, active-low
- en  in  1  run enable; when low the dwell counter freezes
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction, 1 = write
- pready  in  1  slave ready
- pslverr  in  1  slave error
- prdata  in  32  slave read data
- phase  out  3  current expected phase, 0..5
- status  out  32  last status word read
- busy  out  1  high while an APB transfer is in flight
- err  out  1  sticky fault flag

Behaviour:
- Reset (async, presetn=0): every output is 0 (paddr, pwdata, psel, penable, pwrite, phase, status, busy, err); FSM goes to INIT_RD, dwell counter is 0.
- Expected status per phase, packed as A in bits[2:0] and B in bits[18:16] with R=001, Y=010, G=100:
  - phase 0: 0x0001_0004
  - phase 1: 0x0001_0002
  - phase 2: 0x0001_0001
  - phase 3: 0x0004_0001
  - phase 4: 0x0002_0001
  - phase 5: 0x0001_0001
- Dwell per phase: 0,3 = T_GREEN; 1,4 = T_YELLOW; 2,5 = T_ALLRED. A dwell value of 0 is treated as 1.
- FSM states: INIT_RD, DWELL, W_SETUP, W_ACCESS, GAP, R_SETUP, R_ACCESS, CHECK, FAULT.
- INIT_RD:
  - Entered only after reset. Next cycle goes to R_SETUP, so the first check confirms phase 0 with no write.
- DWELL:
  - Counter increments each cycle while en=1 and holds while en=0.
  - When counter == dwell-1 and en=1: clear counter, go to W_SETUP.
- W_SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=ADDR_CTRL, pwdata=32'h1, busy=1.
- W_ACCESS:
  - penable=1; all other bus signals held stable.
  - Waits for pready=1, counting wait cycles.
  - On pready: pslverr=1 goes to FAULT. Otherwise phase = (phase==5) ? 0 : phase+1, then go to GAP.
- GAP (1 cycle): psel=0, penable=0, busy=0. Gives the slave time to update its lamp register before readback.
- R_SETUP: psel=1, penable=0, pwrite=0, paddr=ADDR_STAT, busy=1.
- R_ACCESS:
  - penable=1; waits for pready.
  - On pready: status <= prdata. pslverr=1 goes to FAULT, otherwise CHECK.
- CHECK (1 cycle): psel=0, penable=0, busy=0. status == expected(phase) goes to DWELL; mismatch goes to FAULT.
- Timeout: if a W_ACCESS or R_ACCESS lasts TIMEOUT cycles without pready, go to FAULT.
- FAULT:
  - err=1, psel=0, penable=0, busy=0.
  - Terminal; only presetn exits it.
- Transfer atomicity:
  - en is sampled only in DWELL. Dropping en mid-transfer does not abort it; the write/read/check completes, then DWELL holds.
- Bus idle: psel and penable are 0 in every state except *_SETUP and *_ACCESS; pwdata is 0 during reads.
- Reset mid-transfer: bus is released immediately (async) and phase returns to 0.

Optional Feature:
- Macro: TLC_SEQ_MANUAL_STEP_EN
- Defined:
  - Adds input port step (1 bit).
  - A one-cycle step=1 in DWELL ends the dwell immediately, regardless of en and counter, and goes to W_SETUP with the counter cleared.
  - step is ignored in every other state.
- Undefined: no step port; phase advance is driven by the dwell counter only.

Test Plan:
- Reset then en=1 with a model slave: first bus op is a read of 0x00 returning 0x0001_0004; err stays 0; DWELL lasts 16 cycles; then a write of 0x04 with pwdata=1.
- Full cycle, en=1 for 200 cycles: phase sequence 0,1,2,3,4,5,0. Each status read matches the table (0x00040001 in phase 3, 0x00020001 in phase 4); err=0.
- en dropped at dwell count 5 of phase 0 for 10 cycles, then raised: write occurs exactly 11 counted cycles later; no bus activity while en=0.
- Slave returns pslverr=1 on the CTRL write: err=1, FSM in FAULT, psel=0 thereafter; phase does not advance.
- Slave holds pready=0 in R_ACCESS: after 15 cycles err=1, psel=0, busy=0.
- Slave forced to return 0x0001_0001 in phase 0 (status mismatch): err=1 at CHECK and status=0x0001_0001. With TLC_SEQ_MANUAL_STEP_EN, a step pulse at dwell count 2 makes the write start the next cycle.
